// File: rtl/gbc_gamepak_pkg.sv
// -----------------------------------------------------------------------------
// gbc_gamepak_pkg
//
// Shared types and constants for the cartridge-side GamePak bus responder:
//   - state_e  : responder FSM states
//   - region_e : decoded address region of a console access
//   - ROM_END / SRAM_BASE / SRAM_END : region boundaries
//   - decode_region() : maps a console address + CS_n to a region
// -----------------------------------------------------------------------------
package gbc_gamepak_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        RREQ,
        WREQ
    } state_e;

    typedef enum logic [1:0] {
        NONE,
        ROM,
        SRAM
    } region_e;

    localparam logic [15:0] ROM_END   = 16'h7FFF;
    localparam logic [15:0] SRAM_BASE = 16'hA000;
    localparam logic [15:0] SRAM_END  = 16'hBFFF;

    // ROM answers regardless of CS_n; cartridge SRAM only while CS_n is low.
    function automatic region_e decode_region(input logic [15:0] addr,
                                              input logic        cs_n);
        region_e r;
        r = NONE;
        if (addr <= ROM_END) begin
            r = ROM;
        end else if ((addr >= SRAM_BASE) && (addr <= SRAM_END) && !cs_n) begin
            r = SRAM;
        end
        return r;
    endfunction

endpackage

// File: rtl/gbc_pak_synchronizer.sv
// -----------------------------------------------------------------------------
// gbc_pak_synchronizer
//
// Two-flop synchronizer for a bundle of asynchronous cartridge-edge pins.
// Each bit has its own reset value so idle-high strobes come out of reset
// inactive.
//
// Ports:
//   clk    in   core clock
//   rst_n  in   asynchronous active-low reset
//   d      in   WIDTH raw asynchronous inputs
//   q      out  WIDTH synchronized outputs (two clk cycles of latency)
// -----------------------------------------------------------------------------
module gbc_pak_synchronizer #(
    parameter int               WIDTH       = 27,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            // NOTE: non-blocking assignments make meta and q two distinct
            // flop stages; blocking here would collapse them into one.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gbc_gamepak_responder.sv
// -----------------------------------------------------------------------------
// gbc_gamepak_responder
//
// Cartridge-side responder for the Game Boy GamePak bus. Samples the console's
// asynchronous pins, qualifies reads (address/CS must be stable for
// STABLE_CYCLES) and writes (WR_n rising edge), and turns each into a single
// Wishbone-style request to the backing ROM/SRAM/mapper fabric. Read data is
// held and driven back to the console while the same address stays selected.
//
// Ports:
//   clk           in   core clock
//   rst_n         in   asynchronous active-low reset
//   pak_address   in   console address pins (async)
//   pak_data_in   in   console data pins, write data (async)
//   pak_rd_n      in   console RD, active low (async)
//   pak_wr_n      in   console WR, active low (async)
//   pak_cs_n      in   console SRAM chip select, active low (async)
//   pak_data_out  out  read data to the console
//   pak_data_oe   out  drive enable for pak_data_out
//   mem_addr      out  request address (raw console address)
//   mem_ram       out  1 = SRAM region, 0 = ROM region
//   mem_we        out  write request
//   mem_data_out  out  write data
//   mem_cyc       out  request active, held until ack or timeout
//   mem_stb       out  request strobe, same timing as mem_cyc
//   mem_data_in   in   read data, valid with mem_ack
//   mem_ack       in   single-cycle completion
//   timeout_err   out  sticky: a request timed out
//   overrun       out  sticky: a pending write was overwritten
// -----------------------------------------------------------------------------
module gbc_gamepak_responder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pak_address,
    input  logic [7:0]  pak_data_in,
    input  logic        pak_rd_n,
    input  logic        pak_wr_n,
    input  logic        pak_cs_n,
    output logic [7:0]  pak_data_out,
    output logic        pak_data_oe,
    output logic [15:0] mem_addr,
    output logic        mem_ram,
    output logic        mem_we,
    output logic [7:0]  mem_data_out,
    output logic        mem_cyc,
    output logic        mem_stb,
    input  logic [7:0]  mem_data_in,
    input  logic        mem_ack,
    output logic        timeout_err,
    output logic        overrun
);

    import gbc_gamepak_pkg::*;

    localparam logic [3:0]  SETTLE_LAST  = 4'(STABLE_CYCLES - 1);
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    // Bundle order {cs_n, wr_n, rd_n, data, address}: strobes idle high.
    localparam logic [26:0] SYNC_RESET   = {3'b111, 8'h00, 16'h0000};

    // ------------------------------------------------------------------
    // Pin synchronization
    // ------------------------------------------------------------------
    logic [26:0] sync_bus;
    logic [15:0] s_addr;
    logic [7:0]  s_data;
    logic        s_rd_n;
    logic        s_wr_n;
    logic        s_cs_n;

    gbc_pak_synchronizer #(
        .WIDTH       (27),
        .RESET_VALUE (SYNC_RESET)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({pak_cs_n, pak_wr_n, pak_rd_n, pak_data_in, pak_address}),
        .q     (sync_bus)
    );

    assign {s_cs_n, s_wr_n, s_rd_n, s_data, s_addr} = sync_bus;

    region_e cur_region;
    logic    cur_mapped;

    assign cur_region = decode_region(s_addr, s_cs_n);
    assign cur_mapped = (cur_region != NONE);

    // ------------------------------------------------------------------
    // Write capture (independent of the FSM)
    // ------------------------------------------------------------------
    logic        prev_wr_n;
    logic        write_pending;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    region_e     wr_region;
    logic        wr_rise;
    logic        take_write;
    logic        wp_clear;

    state_e      state;
    logic [7:0]  tcnt;
    logic        t_expired;

    assign wr_rise    = ~prev_wr_n & s_wr_n;
    // The FSM may consume a write in the same cycle its edge is detected.
    assign take_write = write_pending | wr_rise;
    assign t_expired  = (tcnt == TIMEOUT_LAST);

    assign wp_clear = ((state == IDLE) && take_write && (wr_region == NONE)) ||
                      ((state == WREQ) && (mem_ack || t_expired));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_wr_n     <= 1'b1;
            write_pending <= 1'b0;
            wr_addr       <= '0;
            wr_data       <= '0;
            wr_region     <= NONE;
            overrun       <= 1'b0;
        end else begin
            prev_wr_n <= s_wr_n;
            if (!s_wr_n) begin
                wr_addr   <= s_addr;
                wr_data   <= s_data;
                wr_region <= cur_region;
            end
            if (wr_rise) begin
                // A new edge always wins over a clear; a write is lost only
                // when the previous one is still waiting and not completing.
                write_pending <= 1'b1;
                if (write_pending && !wp_clear) begin
                    overrun <= 1'b1;
                end
            end else if (wp_clear) begin
                write_pending <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request FSM, read hold and registered outputs
    // ------------------------------------------------------------------
    logic [3:0]  settle_cnt;
    logic [15:0] settle_addr;
    logic        settle_cs_n;
    logic [15:0] held_addr;
    logic        hold_valid;
    logic        read_start;

    assign read_start = ~s_rd_n & s_wr_n & cur_mapped &
                        (~hold_valid | (s_addr != held_addr));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            settle_cnt   <= '0;
            settle_addr  <= '0;
            settle_cs_n  <= 1'b1;
            tcnt         <= '0;
            held_addr    <= '0;
            hold_valid   <= 1'b0;
            pak_data_out <= 8'hFF;
            pak_data_oe  <= 1'b0;
            mem_addr     <= '0;
            mem_ram      <= 1'b0;
            mem_we       <= 1'b0;
            mem_data_out <= '0;
            mem_cyc      <= 1'b0;
            mem_stb      <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            pak_data_oe <= hold_valid & ~s_rd_n & s_wr_n &
                           (s_addr == held_addr) & cur_mapped;

            case (state)
                IDLE: begin
                    if (take_write) begin
                        // Unmapped writes are dropped via wp_clear.
                        if (wr_region != NONE) begin
                            state        <= WREQ;
                            mem_addr     <= wr_addr;
                            mem_data_out <= wr_data;
                            mem_ram      <= (wr_region == SRAM);
                            mem_we       <= 1'b1;
                            mem_cyc      <= 1'b1;
                            mem_stb      <= 1'b1;
                            tcnt         <= '0;
                        end
                    end else if (read_start) begin
                        state       <= SETTLE;
                        settle_cnt  <= '0;
                        settle_addr <= s_addr;
                        settle_cs_n <= s_cs_n;
                    end
                end

                SETTLE: begin
                    if (s_rd_n || !s_wr_n) begin
                        state <= IDLE;
                    end else if ((s_addr != settle_addr) || (s_cs_n != settle_cs_n)) begin
                        settle_cnt  <= '0;
                        settle_addr <= s_addr;
                        settle_cs_n <= s_cs_n;
                        // Settled onto an unmapped or already-held address.
                        if (!read_start) begin
                            state <= IDLE;
                        end
                    end else if (settle_cnt == SETTLE_LAST) begin
                        state    <= RREQ;
                        mem_addr <= s_addr;
                        mem_ram  <= (cur_region == SRAM);
                        mem_we   <= 1'b0;
                        mem_cyc  <= 1'b1;
                        mem_stb  <= 1'b1;
                        tcnt     <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end

                RREQ: begin
                    if (mem_ack || t_expired) begin
                        // A timed-out read is still held, returning 0xFF
                        // like an empty bus, so the console is not re-served.
                        pak_data_out <= mem_ack ? mem_data_in : 8'hFF;
                        held_addr    <= mem_addr;
                        hold_valid   <= 1'b1;
                        if (!mem_ack) begin
                            timeout_err <= 1'b1;
                        end
                        mem_cyc <= 1'b0;
                        mem_stb <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end

                WREQ: begin
                    if (mem_ack || t_expired) begin
                        if (!mem_ack) begin
                            timeout_err <= 1'b1;
                        end
                        mem_cyc <= 1'b0;
                        mem_stb <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end

                default: state <= IDLE;
            endcase

            // A write may switch mapper banks, so held read data is stale.
            if (!s_wr_n) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/gbc_gamepak_responder.md
# gbc_gamepak_responder

Cartridge-side responder for the Game Boy GamePak bus: the opposite end of the GamePak controller interface. It samples the console's asynchronous cartridge pins (address, data, RD, WR, CS) and turns each qualified read or write into a single-beat Wishbone-style request to a backing ROM/SRAM store or mapper. It returns read data on the pak data pins with an output enable. It sits between the cartridge-edge I/O pins and the mapper/cartridge-RAM fabric when the FPGA emulates a GamePak plugged into a real console.

## Interface
Parameters:
- StableCycles, 4, consecutive Clk cycles the synchronized address/CS must hold unchanged before a read is issued (1..15)
- TimeoutCycles, 255, maximum Clk cycles to wait for MemAck before aborting (1..255)

Ports:
- Clk  in  1  core clock (rising edge)
- Reset  in  1  asynchronous, active-low reset
- PakAddress  in  16  console address pins, asynchronous
- PakDataIn  in  8  console data pins (write data), asynchronous
- PakRd_n  in  1  console RD, active-low, asynchronous
- PakWr_n  in  1  console WR, active-low, asynchronous
- PakCs_n  in  1  console SRAM chip select, active-low, asynchronous
- PakDataOut  out  8  read data to console
- PakDataOe  out  1  drive enable for PakDataOut
- MemAddr  out  16  request address (raw console address)
- MemRam  out  1  1 = SRAM region, 0 = ROM region
- MemWe  out  1  write request
- MemDataOut  out  8  write data
- MemCyc, MemStb  out  1  request active, held until ack or timeout
- MemDataIn  in  8  read data, valid with MemAck
- MemAck  in  1  single-cycle completion
- TimeoutErr  out  1  sticky; set on any timeout
- Overrun  out  1  sticky; set when a write is lost

## Operation
- All pak inputs pass through a 2-flop synchronizer. All logic below uses synchronized values.
- Region decode: ROM = 0x0000–0x7FFF. SRAM = 0xA000–0xBFFF with Cs_n low. Every other address is unmapped: no request is issued and PakDataOe stays 0.
- Write capture runs independently of the FSM:
  - While Wr_n is low, latch address, data and region every cycle.
  - On Wr_n rising, set WritePending with the last latched values.
  - A rising edge while WritePending is already set overwrites the pending write and sets Overrun.
  - Any write clears HoldValid, because the write may switch banks.
- FSM states: IDLE, SETTLE, RREQ, WREQ.
  - IDLE: WritePending and mapped region → WREQ. An unmapped pending write is dropped and WritePending is cleared. Otherwise, if Rd_n is low, Wr_n is high, the region is mapped, and (the address differs from HeldAddr or HoldValid = 0) → SETTLE with the counter cleared.
  - SETTLE: a change in address or Cs_n restarts the counter. Rd_n high or Wr_n low → IDLE. When the counter reaches StableCycles−1 → RREQ.
  - RREQ: assert MemCyc/MemStb with MemWe=0. On MemAck, register PakDataOut=MemDataIn, HeldAddr=address, set HoldValid → IDLE. On timeout, PakDataOut=0xFF, HoldValid=1, set TimeoutErr → IDLE.
  - WREQ: assert MemCyc/MemStb/MemWe with the pending address, data and region. On MemAck or timeout (setting TimeoutErr), clear WritePending → IDLE.
- PakDataOe is registered. It equals HoldValid & ~Rd_n & Wr_n & (address==HeldAddr) & mapped region, and deasserts the cycle after any of these terms fall.
- The timeout counter is 8 bits and is cleared on entry to RREQ/WREQ. Timeout fires when count == TimeoutCycles−1 without MemAck.
- MemAck outside RREQ/WREQ is ignored.

## Timing
- Reset values: PakDataOut=0xFF; PakDataOe=0; MemCyc/MemStb/MemWe=0; MemAddr=0; MemRam=0; MemDataOut=0; TimeoutErr=0; Overrun=0; state IDLE; HoldValid=0; WritePending=0.
- Reset asserted mid-request drops MemCyc/MemStb asynchronously. No completion is reported.
- Read latency, from a pin change to MemStb: 2 (sync) + 1 (IDLE) + StableCycles Clk cycles. With MemAck on the first request cycle, PakDataOe rises 2 cycles after MemAck.
- Write request: MemStb rises 3 cycles after the Wr_n rising edge at the pins, provided the FSM is idle.
- Request signals change only on Clk rising edges. MemAddr, MemRam, MemWe and MemDataOut are stable while MemStb is high.
- Simultaneous WritePending and read condition in IDLE: the write wins.

## Structure
- Package gbc_gamepak_pkg holds:
  - the state enum (IDLE, SETTLE, RREQ, WREQ)
  - the region enum (NONE, ROM, SRAM)
  - constants ROM_END=16'h7FFF, SRAM_BASE=16'hA000, SRAM_END=16'hBFFF
- Sub-module gbc_pak_synchronizer: parameterized-width 2-flop synchronizer with asynchronous active-low reset, instantiated once for the 27 pak input bits. Reset value is 1 for Rd_n/Wr_n/Cs_n and 0 for the rest.

## Test plan
- ROM read: Rd_n=0, address 0x0150 held, MemAck returns 0x3E next cycle → one MemStb with MemAddr=0x0150, MemRam=0; PakDataOut=0x3E, PakDataOe=1 until Rd_n rises.
- SRAM read: address 0xA123, Cs_n=0 → MemRam=1, MemAddr=0xA123. The same address with Cs_n=1 → no request and PakDataOe=0.
- Glitchy address: address toggles 0x0100↔0x0101 every 2 cycles, then settles on 0x0101 → exactly one request, for 0x0101, issued StableCycles cycles after settling.
- Write: 0x2000 with data 0x05, Wr_n low for 20 cycles → after the rising edge, one MemWe=1 request with MemAddr=0x2000, MemDataOut=0x05; HoldValid cleared, so the next read of the same address re-fetches.
- Timeout: RREQ with no MemAck → MemStb drops after 255 cycles, PakDataOut=0xFF, TimeoutErr=1 and stays set.
- Overrun/reset: two write pulses while stalled in RREQ → Overrun=1 and only the second write is issued. Asserting Reset during WREQ → MemCyc=0 immediately and all outputs return to their reset values.
